div_n: RTL and testbench
========================

# div_n

Parametrised, runtime-programmable clock divider for the microwave controller timing chain; the next generation of the fixed divide-by-100 stage. It counts enabled system-clock cycles and produces a one-cycle `tick` strobe every N cycles plus a registered, near-50% square wave `clk_out`. N can be reloaded at run time, so one instance can serve both the display-scan and countdown time bases. All outputs are synchronous to `clk`.

## Interface
- `WIDTH`, 8, width of the divisor and counter; legal range 2..16.
- `DEFAULT_DIV`, 100, divisor after reset; legal range 2..2^WIDTH-1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable; when low, the counter and `clk_out` hold.
- `load`  in  1  single-cycle request to replace the divisor with `div_in`.
- `div_in`  in  WIDTH  new divisor N, sampled only when `load` is high.
- `tick`  out  1  one-cycle strobe, once per N enabled cycles.
- `clk_out`  out  1  divided square wave, registered.
- `count`  out  WIDTH  current counter value, 0..N-1.
- `div_cur`  out  WIDTH  divisor currently in effect.
- `load_err`  out  1  one-cycle strobe when a load is rejected.

Reset and clocking are fixed: one clock; reset is asynchronous and active-high.

## Operation
- **Reset values.** While `rst` is high, all outputs take these values immediately, without waiting for a clock edge:
  - `count`=0, `tick`=0, `clk_out`=0, `load_err`=0
  - `div_cur`=`DEFAULT_DIV`
- **Registers.** The block holds the divisor register D, counter C, and the `tick`, `clk_out` and `load_err` flops.
- **Priority at each edge, highest first:**
  - `load`
  - `en`
  - hold
- **Load with `div_in` >= 2.** D takes `div_in`, C goes to 0, `clk_out` goes to 0, `tick` goes to 0, `load_err` goes to 0. `en` is ignored that cycle.
- **Load with `div_in` < 2.** D, C and `clk_out` are unchanged, `tick` goes to 0, and `load_err` pulses for one cycle. `en` is ignored that cycle.
- **Enabled count (`en`=1, no load).**
  - If C == D-1: C wraps to 0 and `tick` goes to 1.
  - Otherwise: C increments by 1 and `tick` goes to 0.
- **Disabled (`en`=0, no load).** C and `clk_out` hold; `tick` goes to 0.
- **`clk_out` rule.** `clk_out` is registered from the next value of C, so it is glitch-free. After every edge the invariant `clk_out` == (C >= H) holds, where H = D - (D>>1) = ceil(D/2).
  - Low for ceil(N/2) cycles, high for floor(N/2) cycles.
  - N=100 gives 50/50; N=7 gives 4 low, 3 high.
- **Arithmetic.** All comparisons are unsigned, WIDTH bits wide. C never exceeds D-1, because loading resets C.
- **`load_err` pulse.** It is high only in the cycle after a rejected load.

## Timing
- **Latency.** Every output is registered; an input change shows up on outputs one edge later.
- **First tick after reset or load.** With `en` held high from the first edge, C goes 1..N-1 on edges 1..N-1. On edge N, C becomes 0 and `tick` goes to 1. On edge N+1, `tick` goes to 0. The tick period is then exactly N cycles.
- **`clk_out` edges.** `clk_out` rises at the edge where C becomes H and falls at the edge where C wraps to 0. That falling edge coincides with `tick` going high.
- **Load coinciding with a wrap** (C == D-1): the load wins. No tick is produced, and counting restarts from 0 with the new D.
- **`en` dropping exactly at C == D-1:** no wrap and no tick occur. The wrap happens on the next enabled edge.
- **`rst` asserted mid-count:** immediate return to the reset values. The first edge after `rst` falls behaves as the first edge after reset.
- **Back-to-back loads:** each one is evaluated independently; the last accepted load wins.

## Test plan
- **Reset values.** Assert `rst` asynchronously between edges → all outputs take their reset values immediately; `div_cur`=100.
- **Default divisor.** Release `rst`, hold `en`=1 for 300 cycles → `tick` high at edges 100, 200 and 300 only. `clk_out` is low for 50 cycles, then high for 50, on each period.
- **Runtime load.** Load `div_in`=7, then hold `en`=1 → `div_cur`=7 and C restarts at 0. The first `tick` comes 7 edges after the load. `clk_out` repeats the pattern 0,0,0,0,1,1,1.
- **Enable gating.** With N=7 and C=3, drop `en` for 5 cycles → C stays 3, `clk_out` holds, no `tick`. After re-enable, the next tick comes 4 enabled edges later.
- **Rejected loads.** Load `div_in`=1, then `div_in`=0 → each produces a 1-cycle `load_err`. D, C and `clk_out` are unchanged; counting stays suspended only for each load cycle.
- **Load on wrap, then reset.** With N=7, load `div_in`=4 exactly when C=6 → no tick, C=0, and the next tick comes 4 edges later. Then assert `rst` mid-count at C=2 → C=0 immediately and `div_cur`=100.

Source files
------------

// File: rtl/div_n_if.sv
// -----------------------------------------------------------------------------
// div_n_if -- control and status bundle of the div_n clock divider.
//
//   en        count enable (master -> slave)
//   load      single-cycle divisor reload request (master -> slave)
//   div_in    new divisor, sampled with load (master -> slave)
//   tick      one-cycle strobe per N enabled cycles (slave -> master)
//   clk_out   registered divided square wave (slave -> master)
//   count     current counter value 0..N-1 (slave -> master)
//   div_cur   divisor currently in effect (slave -> master)
//   load_err  one-cycle strobe after a rejected load (slave -> master)
// -----------------------------------------------------------------------------
interface div_n_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] div_in;
   logic             tick;
   logic             clk_out;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] div_cur;
   logic             load_err;

   modport master (
      output en, load, div_in,
      input  tick, clk_out, count, div_cur, load_err
   );

   modport slave (
      input  en, load, div_in,
      output tick, clk_out, count, div_cur, load_err
   );
endinterface : div_n_if

// File: rtl/div_n.sv
// -----------------------------------------------------------------------------
// div_n -- runtime-programmable clock divider.
//
// Counts enabled clk cycles modulo the divisor N, producing a one-cycle tick
// on each wrap and a registered square wave clk_out that is low for ceil(N/2)
// and high for floor(N/2) cycles of each period. N is reloadable at run time;
// divisors below 2 are rejected with a one-cycle load_err.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   div_n_if slave modport (en, load, div_in in; tick, clk_out, count,
//         div_cur, load_err out)
// Parameters:
//   WIDTH        counter/divisor width, 2..16
//   DEFAULT_DIV  divisor after reset, 2..2^WIDTH-1
// -----------------------------------------------------------------------------
module div_n #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 100
) (
   input logic    clk,
   input logic    rst,
   div_n_if.slave bus
);

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] count_q;
   logic             tick_q;
   logic             clk_out_q;
   logic             load_err_q;

   logic [WIDTH-1:0] half;
   logic [WIDTH-1:0] count_inc;
   logic             at_wrap;
   logic             load_ok;

   // NOTE: every signal is assigned unconditionally here, so no latch can be inferred.
   always_comb begin
      half      = div_q - (div_q >> 1);          // ceil(D/2): first high count
      count_inc = count_q + WIDTH'(1);
      at_wrap   = (count_q == div_q - WIDTH'(1));
      load_ok   = (bus.div_in >= WIDTH'(2));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q      <= DIV_RST;
         count_q    <= '0;
         tick_q     <= 1'b0;
         clk_out_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else if (bus.load) begin
         // A load outranks counting: en is ignored and no tick can be produced.
         tick_q <= 1'b0;
         if (load_ok) begin
            div_q      <= bus.div_in;
            count_q    <= '0;
            clk_out_q  <= 1'b0;
            load_err_q <= 1'b0;
         end else begin
            load_err_q <= 1'b1;
         end
      end else begin
         load_err_q <= 1'b0;
         tick_q     <= 1'b0;
         if (bus.en) begin
            if (at_wrap) begin
               count_q   <= '0;
               tick_q    <= 1'b1;
               clk_out_q <= 1'b0;          // 0 is always below half
            end else begin
               count_q   <= count_inc;
               // Registered from the next count so clk_out tracks C >= H.
               clk_out_q <= (count_inc >= half);
            end
         end
      end
   end

   assign bus.tick     = tick_q;
   assign bus.clk_out  = clk_out_q;
   assign bus.count    = count_q;
   assign bus.div_cur  = div_q;
   assign bus.load_err = load_err_q;

endmodule : div_n

// File: tb/tb_div_n.sv
// -----------------------------------------------------------------------------
// tb_div_n -- self-checking bench for div_n.
//
// A behavioural model tracks the divisor and a modulo-N cycle count; expected
// outputs are derived from it (tick on reaching 0 by counting, clk_out as
// count >= ceil(N/2)). Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_div_n;

   localparam int W   = 8;
   localparam int DEF = 100;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   div_n_if #(.WIDTH(W)) bus ();

   div_n #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int m_d;
   int m_c;
   bit m_tick;
   bit m_err;

   function automatic logic [2*W+2:0] expected_vec();
      logic hi;
      hi = (m_c >= (m_d + 1) / 2) ? 1'b1 : 1'b0;
      return {m_tick, hi, W'(m_c), W'(m_d), m_err};
   endfunction

   function automatic logic [2*W+2:0] observed_vec();
      return {bus.tick, bus.clk_out, bus.count, bus.div_cur, bus.load_err};
   endfunction

   task automatic model_reset();
      m_d    = DEF;
      m_c    = 0;
      m_tick = 1'b0;
      m_err  = 1'b0;
   endtask

   // Drive one cycle of inputs, sample #1 after the edge, advance the model.
   task automatic step(input bit e, input bit l, input int d);
      bus.en     = e;
      bus.load   = l;
      bus.div_in = W'(d);
      @(posedge clk);
      #1;
      if (l) begin
         m_tick = 1'b0;
         if (d >= 2) begin
            m_d   = d;
            m_c   = 0;
            m_err = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end else begin
         m_err = 1'b0;
         if (e) begin
            m_c    = (m_c + 1) % m_d;
            m_tick = (m_c == 0);
         end else begin
            m_tick = 1'b0;
         end
      end
      bus.load = 1'b0;
   endtask

   // {tick, clk_out, count, div_cur, load_err} in hex for FAIL lines
   task automatic test_reset();
      rst        = 1'b1;
      bus.en     = 1'b0;
      bus.load   = 1'b0;
      bus.div_in = '0;
      model_reset();
      #3;
      checks++;
      if (observed_vec() !== expected_vec()) begin
         errors++;
         $display("FAIL reset_initial got %h want %h", observed_vec(), expected_vec());
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
      checks++;
      if (observed_vec() !== expected_vec()) begin
         errors++;
         $display("FAIL reset_count5 got %h want %h", observed_vec(), expected_vec());
      end
      // Asynchronous assertion between edges must act immediately.
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (observed_vec() !== expected_vec() || bus.div_cur !== W'(100)) begin
         errors++;
         $display("FAIL reset_async got %h want %h", observed_vec(), expected_vec());
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_default();
      int tick_edges[$];
      for (int i = 1; i <= 300; i++) begin
         step(1'b1, 1'b0, 0);
         checks++;
         if (observed_vec() !== expected_vec()) begin
            errors++;
            $display("FAIL default edge %0d got %h want %h", i, observed_vec(), expected_vec());
         end
         if (bus.tick === 1'b1) tick_edges.push_back(i);
      end
      checks++;
      if (tick_edges.size() != 3 || tick_edges[0] != 100 || tick_edges[1] != 200 ||
          tick_edges[2] != 300) begin
         errors++;
         $display("FAIL default_tick_edges got %0d ticks want 3 at 100,200,300", tick_edges.size());
      end
   endtask

   task automatic test_load();
      bit pat [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      step(1'b1, 1'b1, 7);
      checks++;
      if (observed_vec() !== expected_vec() || bus.div_cur !== W'(7) || bus.count !== '0) begin
         errors++;
         $display("FAIL load7 got %h want %h", observed_vec(), expected_vec());
      end
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 0);
            checks++;
            if (observed_vec() !== expected_vec() || bus.clk_out !== pat[i] ||
                bus.tick !== ((i == 6) ? 1'b1 : 1'b0)) begin
               errors++;
               $display("FAIL load7_pattern edge %0d got %h want %h", i + 1,
                        observed_vec(), expected_vec());
            end
         end
      end
   endtask

   task automatic test_enable_gating();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 0);
         checks++;
         if (observed_vec() !== expected_vec() || bus.count !== W'(3) || bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL gate_hold cyc %0d got %h want %h", i, observed_vec(), expected_vec());
         end
      end
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 1'b0, 0);
         checks++;
         if (observed_vec() !== expected_vec() || bus.tick !== ((i == 4) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL gate_resume edge %0d got %h want %h", i, observed_vec(), expected_vec());
         end
      end
   endtask

   task automatic test_rejected();
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1);
      checks++;
      if (observed_vec() !== expected_vec() || bus.load_err !== 1'b1) begin
         errors++;
         $display("FAIL reject_div1 got %h want %h", observed_vec(), expected_vec());
      end
      step(1'b1, 1'b1, 0);
      checks++;
      if (observed_vec() !== expected_vec() || bus.load_err !== 1'b1 || bus.div_cur !== W'(7)) begin
         errors++;
         $display("FAIL reject_div0 got %h want %h", observed_vec(), expected_vec());
      end
      step(1'b1, 1'b0, 0);
      checks++;
      if (observed_vec() !== expected_vec() || bus.load_err !== 1'b0) begin
         errors++;
         $display("FAIL reject_resume got %h want %h", observed_vec(), expected_vec());
      end
   endtask

   task automatic test_load_on_wrap_reset();
      for (int i = 0; i < 8 && m_c != 6; i++) step(1'b1, 1'b0, 0);
      checks++;
      if (observed_vec() !== expected_vec() || bus.count !== W'(6)) begin
         errors++;
         $display("FAIL wrap_setup got %h want %h", observed_vec(), expected_vec());
      end
      step(1'b1, 1'b1, 4);
      checks++;
      if (observed_vec() !== expected_vec() || bus.tick !== 1'b0 || bus.count !== '0) begin
         errors++;
         $display("FAIL load_on_wrap got %h want %h", observed_vec(), expected_vec());
      end
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 1'b0, 0);
         checks++;
         if (observed_vec() !== expected_vec() || bus.tick !== ((i == 4) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL wrap_next_tick edge %0d got %h want %h", i, observed_vec(), expected_vec());
         end
      end
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (observed_vec() !== expected_vec() || bus.count !== '0 || bus.div_cur !== W'(100)) begin
         errors++;
         $display("FAIL midcount_reset got %h want %h", observed_vec(), expected_vec());
      end
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0, 0);
      checks++;
      if (observed_vec() !== expected_vec() || bus.count !== W'(1)) begin
         errors++;
         $display("FAIL post_reset_edge got %h want %h", observed_vec(), expected_vec());
      end
   endtask

   task automatic test_random();
      bit e;
      bit l;
      int d;
      for (int i = 0; i < 3000; i++) begin
         e = ($urandom_range(0, 3) != 0);
         l = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 3))
            0:       d = $urandom_range(0, 3);
            1:       d = $urandom_range(2, 255);
            default: d = $urandom_range(2, 12);
         endcase
         if ($urandom_range(0, 499) == 0) begin
            #2;
            rst = 1'b1;
            #1;
            model_reset();
            checks++;
            if (observed_vec() !== expected_vec()) begin
               errors++;
               $display("FAIL random_reset cyc %0d got %h want %h", i, observed_vec(), expected_vec());
            end
            @(negedge clk);
            rst = 1'b0;
         end
         step(e, l, d);
         checks++;
         if (observed_vec() !== expected_vec()) begin
            errors++;
            $display("FAIL random cyc %0d en %0b load %0b div_in %0d got %h want %h",
                     i, e, l, d, observed_vec(), expected_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_default();
      test_load();
      test_enable_gating();
      test_rejected();
      test_load_on_wrap_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_div_n
